multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32I core subset: R-type, ADDI-class I-type, LW, SW and BEQ.
- Replaces single-cycle control with a Moore FSM that drives the shared ALU, register file, PC/IR and one unified memory port over several cycles.
- Handles a req/ready memory handshake with timeout, traps on illegal opcodes and counts retired instructions.
- Sits between the IR opcode field and the datapath mux/enable controls.

Parameters:
- CNT_W, 32, width of retired-instruction counter instret.
- TIMEOUT, 16, max cycles mem_req may wait for mem_ready before a bus-error trap (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  7  IR[6:0]; stable from DECODE until return to FETCH.
- zero  in  1  ALU zero flag, same-cycle combinational.
- mem_ready  in  1  memory accepted/completed current request.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  1 = store, 0 = read; valid with mem_req.
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR (also old_pc <= PC).
- pc_write  out  1  load PC.
- pc_src  out  1  PC source: 0 = ALU result, 1 = ALUOut register.
- alu_src_a  out  2  00 PC, 01 old_pc, 10 rs1.
- alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4.
- alu_op  out  2  00 add, 01 sub/compare, 10 funct-decoded.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  writeback select: 1 = MDR, 0 = ALUOut.
- illegal  out  1  sticky illegal-opcode trap.
- bus_err  out  1  sticky memory-timeout trap.
- instret  out  CNT_W  retired instruction count.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Reset (async, rst_n = 0): state IDLE; all outputs 0; instret 0; wait counter 0. One cycle after release, IDLE -> FETCH.
- Outputs are pure functions of state, plus opcode/zero/mem_ready where listed. Unlisted outputs are 0.
- FETCH: mem_req=1, iord=0, alu_src_a=00, alu_src_b=10, alu_op=00.
  - On mem_ready in the same cycle: ir_write=1, pc_write=1, pc_src=0, then -> DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (ALUOut <= branch target). Dispatch on opcode:
  - 0110011 or 0010011 -> EXEC.
  - 0000011 or 0100011 -> MEMADR.
  - 1100011 -> BRANCH.
  - Any other opcode -> TRAP with illegal=1.
- EXEC: alu_src_a=10, alu_op=10; alu_src_b=00 for R-type, 01 for I-type. -> ALUWB.
- ALUWB: reg_write=1, mem_to_reg=0; retire. -> FETCH.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. LW -> MEMRD; SW -> MEMWR.
- MEMRD: mem_req=1, iord=1, mem_we=0. On mem_ready -> MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1; retire. -> FETCH.
- MEMWR: mem_req=1, iord=1, mem_we=1. On mem_ready: retire, -> FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, alu_op=01, pc_src=1, pc_write=zero; retire. -> FETCH.
- TRAP: no requests, no writes; absorbing until reset.
- Retire: instret increments by 1 on the cycle named above and wraps modulo 2^CNT_W.
- Wait counter:
  - Clears on entry to FETCH, MEMRD or MEMWR, and whenever mem_ready=1.
  - Increments every cycle mem_req=1 and mem_ready=0.
  - Reaching TIMEOUT with mem_ready still 0 -> TRAP with bus_err=1. mem_req drops that cycle.
  - If mem_ready arrives on the same cycle the count reaches TIMEOUT, the handshake wins: no trap.
- Handshake rules:
  - mem_ready while mem_req=0 is ignored.
  - mem_we and iord stay constant while mem_req is held.
  - Zero-wait memory (mem_ready tied 1) gives these latencies: R/I 4 cycles, LW 5, SW 4, BEQ 3.
- Reset mid-operation forces IDLE immediately; no write strobes are generated during or after assertion.

Decomposition:
- Package rv_ctrl_pkg holds:
  - opcode constants: OP_R, OP_I, OP_LW, OP_SW, OP_BEQ.
  - state enum: IDLE, FETCH, DECODE, EXEC, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH, TRAP.
  - ALU_OP_* and SRC_A_* / SRC_B_* encodings.
- One sub-module, mem_wait_timer: counter plus timeout compare, parameterised by TIMEOUT, with inputs clr/busy/ready and output expired.
- FSM next-state logic and output decode stay in multicycle_ctrl.

Test Plan:
- mem_ready tied 1, opcode 0110011 → states FETCH, DECODE, EXEC, ALUWB. reg_write=1 for exactly one cycle with mem_to_reg=0. instret 0 → 1 after 4 cycles.
- LW (0000011), mem_ready delayed 3 cycles in MEMRD → mem_req=1, iord=1, mem_we=0 held for 4 cycles. Then MEMWB with reg_write=1, mem_to_reg=1; total 8 cycles.
- SW (0100011) then BEQ (1100011) with zero=1, then BEQ with zero=0:
  - SW cycle has mem_we=1 and reg_write never asserts.
  - First BRANCH has pc_write=1, pc_src=1; second has pc_write=0.
  - instret advances by 3.
- opcode 1111111 at DECODE → TRAP, illegal=1. mem_req stays 0 for 20 further cycles; rst_n pulse clears illegal to 0 and restarts via IDLE.
- TIMEOUT=16, mem_ready held 0 in FETCH → after 16 waiting cycles bus_err=1 and mem_req=0. Repeat with mem_ready on wait cycle 16 → no trap, DECODE entered.
- rst_n asserted during MEMWR wait → all outputs 0 asynchronously, state_o=IDLE, instret=0.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I-subset controller.
package rv_ctrl_pkg;

  // Major opcodes of the supported subset (IR[6:0])
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // ALU operation select
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // ALU operand A select
  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    EXEC   = 4'd3,
    ALUWB  = 4'd4,
    MEMADR = 4'd5,
    MEMRD  = 4'd6,
    MEMWB  = 4'd7,
    MEMWR  = 4'd8,
    BRANCH = 4'd9,
    TRAP   = 4'd10
  } state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles and flags a timeout on the last allowed wait cycle.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic busy,
  input  logic ready,
  output logic expired
);

  // Count never exceeds TIMEOUT-1: expiry moves the FSM out of the waiting state.
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] Last = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q;

  // Wait counter: cleared on entry or handshake, advances while request is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || ready) begin
      cnt_q <= '0;
    end else if (busy) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // A same-cycle ready always beats the timeout
  assign expired = busy && !ready && (cnt_q == Last);

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore-style multi-cycle sequencer for R/I-type, LW, SW and BEQ.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_o
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  instret_q;
  logic              illegal_q, bus_err_q;
  logic              retire, set_illegal, set_bus_err;
  logic              timer_clr, expired;

  // Timer restarts whenever a request-issuing state is freshly entered
  assign timer_clr = (state_d != state_q) && (state_d inside {FETCH, MEMRD, MEMWR});

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .busy    (mem_req),
    .ready   (mem_ready),
    .expired (expired)
  );

  // State, retire counter and sticky trap flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      instret_q <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire)      instret_q <= instret_q + CNT_W'(1);
      if (set_illegal) illegal_q <= 1'b1;
      if (set_bus_err) bus_err_q <= 1'b1;
    end
  end

  // Next-state selection, retire strobe and trap causes
  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    set_illegal = 1'b0;
    set_bus_err = 1'b0;
    unique case (state_q)
      IDLE:   state_d = FETCH;
      FETCH: begin
        if (mem_ready) begin
          state_d = DECODE;
        end else if (expired) begin
          state_d     = TRAP;
          set_bus_err = 1'b1;
        end
      end
      DECODE: begin
        case (opcode)
          OP_R, OP_I:   state_d = EXEC;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          default: begin
            state_d     = TRAP;
            set_illegal = 1'b1;
          end
        endcase
      end
      EXEC:   state_d = ALUWB;
      ALUWB: begin
        retire  = 1'b1;
        state_d = FETCH;
      end
      MEMADR: state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
      MEMRD: begin
        if (mem_ready) begin
          state_d = MEMWB;
        end else if (expired) begin
          state_d     = TRAP;
          set_bus_err = 1'b1;
        end
      end
      MEMWB: begin
        retire  = 1'b1;
        state_d = FETCH;
      end
      MEMWR: begin
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end else if (expired) begin
          state_d     = TRAP;
          set_bus_err = 1'b1;
        end
      end
      BRANCH: begin
        retire  = 1'b1;
        state_d = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  // Datapath control decode from current state
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    alu_op     = ALU_OP_ADD;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    unique case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE: begin
        // Precompute branch target into ALUOut
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_IMM;
      end
      EXEC: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = (opcode == OP_I) ? SRC_B_IMM : SRC_B_RS2;
        alu_op    = ALU_OP_FUNCT;
      end
      ALUWB:  reg_write = 1'b1;
      MEMADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      MEMWR: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = 1'b1;
      end
      BRANCH: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_RS2;
        alu_op    = ALU_OP_SUB;
        pc_src    = 1'b1;
        pc_write  = zero;
      end
      default: ;
    endcase
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;
  assign instret = instret_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench: table of zero-wait instruction flows plus hand-written corner sequences.
module tb_multicycle_ctrl;
  import rv_ctrl_pkg::*;

  localparam int unsigned CNT_W = 32;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [6:0]       opcode;
  logic             zero, mem_ready;
  logic             mem_req, mem_we, iord, ir_write, pc_write, pc_src;
  logic [1:0]       alu_src_a, alu_src_b, alu_op;
  logic             reg_write, mem_to_reg, illegal, bus_err;
  logic [CNT_W-1:0] instret;
  logic [3:0]       state_o;
  logic [19:0]      obs;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_ctrl #(.CNT_W(CNT_W), .TIMEOUT(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .illegal    (illegal),
    .bus_err    (bus_err),
    .instret    (instret),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  assign obs = {state_o, mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, illegal, bus_err};

  function automatic logic [19:0] ex(state_e st, logic req, logic we, logic io, logic irw,
                                     logic pcw, logic pcs, logic [1:0] a, logic [1:0] b,
                                     logic [1:0] op, logic rw, logic m2r, logic ill,
                                     logic be);
    logic [3:0] s;
    s = st;
    return {s, req, we, io, irw, pcw, pcs, a, b, op, rw, m2r, ill, be};
  endfunction

  typedef struct {
    logic [6:0]  op;
    logic        z;
    logic        rdy;
    logic [19:0] exp;
    int unsigned ret;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic [6:0] op, logic z, logic rdy, logic [19:0] e,
                              int unsigned r);
    vec_t v;
    v.op = op; v.z = z; v.rdy = rdy; v.exp = e; v.ret = r;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Advance one clock, apply inputs for the new cycle, settle to the falling edge
  task automatic step(logic [6:0] op, logic z, logic rdy);
    @(posedge clk);
    #1;
    opcode = op; zero = z; mem_ready = rdy;
    @(negedge clk);
  endtask

  // Asynchronous reset pulse inside the low clock phase; checks everything is cleared
  task automatic reset_pulse(string name);
    #2 rst_n = 1'b0;
    #1;
    chk({name, " outputs"}, {12'h0, obs}, 32'h0);
    chk({name, " instret"}, instret, 32'h0);
    #1 rst_n = 1'b1;
  endtask

  logic [19:0] e_fetch, e_fetch_wait, e_dec, e_exec_r, e_exec_i, e_aluwb, e_memadr;
  logic [19:0] e_memrd, e_memwb, e_memwr, e_br_t, e_br_nt, e_trap_be, e_trap_ill;

  initial begin
    e_fetch      = ex(FETCH,  1,0,0,1,1,0, 2'b00,2'b10,2'b00, 0,0,0,0);
    e_fetch_wait = ex(FETCH,  1,0,0,0,0,0, 2'b00,2'b10,2'b00, 0,0,0,0);
    e_dec        = ex(DECODE, 0,0,0,0,0,0, 2'b01,2'b01,2'b00, 0,0,0,0);
    e_exec_r     = ex(EXEC,   0,0,0,0,0,0, 2'b10,2'b00,2'b10, 0,0,0,0);
    e_exec_i     = ex(EXEC,   0,0,0,0,0,0, 2'b10,2'b01,2'b10, 0,0,0,0);
    e_aluwb      = ex(ALUWB,  0,0,0,0,0,0, 2'b00,2'b00,2'b00, 1,0,0,0);
    e_memadr     = ex(MEMADR, 0,0,0,0,0,0, 2'b10,2'b01,2'b00, 0,0,0,0);
    e_memrd      = ex(MEMRD,  1,0,1,0,0,0, 2'b00,2'b00,2'b00, 0,0,0,0);
    e_memwb      = ex(MEMWB,  0,0,0,0,0,0, 2'b00,2'b00,2'b00, 1,1,0,0);
    e_memwr      = ex(MEMWR,  1,1,1,0,0,0, 2'b00,2'b00,2'b00, 0,0,0,0);
    e_br_t       = ex(BRANCH, 0,0,0,0,1,1, 2'b10,2'b00,2'b01, 0,0,0,0);
    e_br_nt      = ex(BRANCH, 0,0,0,0,0,1, 2'b10,2'b00,2'b01, 0,0,0,0);
    e_trap_be    = ex(TRAP,   0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,0,0,1);
    e_trap_ill   = ex(TRAP,   0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,0,1,0);

    // Zero-wait flows: R, I, SW, BEQ taken, BEQ not taken, LW
    add(OP_R, 0,1, e_fetch, 0);   add(OP_R, 0,1, e_dec, 0);
    add(OP_R, 0,1, e_exec_r, 0);  add(OP_R, 0,1, e_aluwb, 0);
    add(OP_I, 0,1, e_fetch, 1);   add(OP_I, 0,1, e_dec, 1);
    add(OP_I, 0,1, e_exec_i, 1);  add(OP_I, 0,1, e_aluwb, 1);
    add(OP_SW, 0,1, e_fetch, 2);  add(OP_SW, 0,1, e_dec, 2);
    add(OP_SW, 0,1, e_memadr, 2); add(OP_SW, 0,1, e_memwr, 2);
    add(OP_BEQ, 1,1, e_fetch, 3); add(OP_BEQ, 1,1, e_dec, 3);
    add(OP_BEQ, 1,1, e_br_t, 3);
    add(OP_BEQ, 0,1, e_fetch, 4); add(OP_BEQ, 0,1, e_dec, 4);
    add(OP_BEQ, 0,1, e_br_nt, 4);
    add(OP_LW, 0,1, e_fetch, 5);  add(OP_LW, 0,1, e_dec, 5);
    add(OP_LW, 0,1, e_memadr, 5); add(OP_LW, 0,1, e_memrd, 5);
    add(OP_LW, 0,1, e_memwb, 5);

    // Reset state
    rst_n = 1'b0; opcode = OP_R; zero = 1'b0; mem_ready = 1'b0;
    #2;
    chk("reset outputs", {12'h0, obs}, 32'h0);
    chk("reset instret", instret, 32'h0);
    #1 rst_n = 1'b1;
    #1 chk("idle after release", {12'h0, obs}, {12'h0, ex(IDLE,0,0,0,0,0,0,0,0,0,0,0,0,0)});

    foreach (vecs[i]) begin
      step(vecs[i].op, vecs[i].z, vecs[i].rdy);
      chk($sformatf("vec%0d outputs", i), {12'h0, obs}, {12'h0, vecs[i].exp});
      chk($sformatf("vec%0d instret", i), instret, vecs[i].ret);
    end

    // LW with mem_ready delayed three cycles in MEMRD
    step(OP_LW, 0, 1); chk("lw fetch", {12'h0, obs}, {12'h0, e_fetch});
    chk("lw start instret", instret, 32'd6);
    step(OP_LW, 0, 1); chk("lw decode", {12'h0, obs}, {12'h0, e_dec});
    step(OP_LW, 0, 1); chk("lw memadr", {12'h0, obs}, {12'h0, e_memadr});
    for (int i = 0; i < 4; i++) begin
      step(OP_LW, 0, (i == 3));
      chk($sformatf("lw memrd hold%0d", i), {12'h0, obs}, {12'h0, e_memrd});
    end
    step(OP_LW, 0, 0); chk("lw memwb", {12'h0, obs}, {12'h0, e_memwb});

    // Fetch timeout: 16 stalled cycles then bus-error trap
    for (int c = 1; c <= 16; c++) begin
      step(OP_R, 0, 0);
      chk($sformatf("to fetch wait%0d", c), {12'h0, obs}, {12'h0, e_fetch_wait});
    end
    chk("to instret", instret, 32'd7);
    step(OP_R, 0, 0); chk("to trap", {12'h0, obs}, {12'h0, e_trap_be});
    step(OP_R, 0, 1); chk("to trap held", {12'h0, obs}, {12'h0, e_trap_be});
    reset_pulse("to reset");

    // Ready on the 16th wait cycle: handshake wins
    for (int c = 1; c <= 16; c++) begin
      step(OP_R, 0, (c == 16));
      chk($sformatf("edge fetch%0d", c), {12'h0, obs},
          {12'h0, (c == 16) ? e_fetch : e_fetch_wait});
    end
    step(OP_R, 0, 1); chk("edge decode", {12'h0, obs}, {12'h0, e_dec});
    step(OP_R, 0, 1); chk("edge exec", {12'h0, obs}, {12'h0, e_exec_r});
    step(OP_R, 0, 1); chk("edge aluwb", {12'h0, obs}, {12'h0, e_aluwb});

    // Reset while SW waits in MEMWR
    step(OP_SW, 0, 1); chk("sw fetch", {12'h0, obs}, {12'h0, e_fetch});
    chk("sw instret", instret, 32'd1);
    step(OP_SW, 0, 1); chk("sw decode", {12'h0, obs}, {12'h0, e_dec});
    step(OP_SW, 0, 1); chk("sw memadr", {12'h0, obs}, {12'h0, e_memadr});
    step(OP_SW, 0, 0); chk("sw memwr0", {12'h0, obs}, {12'h0, e_memwr});
    step(OP_SW, 0, 0); chk("sw memwr1", {12'h0, obs}, {12'h0, e_memwr});
    reset_pulse("sw midreset");

    // Illegal opcode: absorbing trap, cleared by reset
    step(OP_BAD, 0, 1); chk("ill fetch", {12'h0, obs}, {12'h0, e_fetch});
    step(OP_BAD, 0, 1); chk("ill decode", {12'h0, obs}, {12'h0, e_dec});
    step(OP_BAD, 0, 1); chk("ill trap", {12'h0, obs}, {12'h0, e_trap_ill});
    for (int i = 0; i < 20; i++) begin
      step(OP_BAD, 1, i[0]);
      chk($sformatf("ill held%0d", i), {12'h0, obs}, {12'h0, e_trap_ill});
    end
    reset_pulse("ill reset");
    step(OP_R, 0, 1); chk("ill restart fetch", {12'h0, obs}, {12'h0, e_fetch});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
